// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command parser: opcodes, parser states and error codes.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_MATMUL = 8'h01;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIM     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ELEM_LO = 3'd3,
    ST_ELEM_HI = 3'd4,
    ST_FIRE    = 3'd5
  } parse_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_DIMS    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } parse_err_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: expired is high in the cycle whose clock edge completes
// TIMEOUT_CYC idle cycles since the last clear.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 43400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_reg;

  // Saturates once expired so a caller that ignores the flag never sees a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = enable && (count_reg >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Host byte-stream parser: decodes opcodes, latches matrix dimensions and streams
// little-endian A then B elements into the operand buffers before starting the core.
module uart_cmd_parser #(
  parameter int DATA_W      = 16,
  parameter int DIM_W       = 16,
  parameter int ADDR_W      = 8,
  parameter int MAX_ELEMS   = 256,
  parameter int TIMEOUT_CYC = 43400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              core_busy,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DIM_W-1:0]  rows_a,
  output logic [DIM_W-1:0]  cols_a,
  output logic [DIM_W-1:0]  cols_b,
  output logic              start,
  output logic              status_req,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              parsing
);

  import uart_cmd_pkg::*;

  localparam int PROD_W = 2 * DIM_W;

  parse_state_t      state_reg;
  logic [2:0]        byte_cnt_reg;
  logic [7:0]        lo_reg;
  logic [ADDR_W-1:0] index_reg;
  logic              sel_reg;

  logic [PROD_W-1:0] n_a;
  logic [PROD_W-1:0] n_b;
  logic              dims_bad;
  logic              last_a;
  logic              last_b;
  logic              expired;

  assign n_a = PROD_W'(rows_a) * PROD_W'(cols_a);
  assign n_b = PROD_W'(cols_a) * PROD_W'(cols_b);

  assign dims_bad = (rows_a == '0) || (cols_a == '0) || (cols_b == '0) ||
                    (n_a > PROD_W'(MAX_ELEMS)) || (n_b > PROD_W'(MAX_ELEMS));

  assign last_a  = PROD_W'(index_reg) == (n_a - PROD_W'(1));
  assign last_b  = PROD_W'(index_reg) == (n_b - PROD_W'(1));
  assign parsing = state_reg != ST_IDLE;

  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid || !parsing),
    .enable  (parsing),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= '0;
      lo_reg       <= '0;
      index_reg    <= '0;
      sel_reg      <= 1'b0;
      wr_en        <= 1'b0;
      wr_sel       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rows_a       <= '0;
      cols_a       <= '0;
      cols_b       <= '0;
      start        <= 1'b0;
      status_req   <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      wr_en      <= 1'b0;
      start      <= 1'b0;
      status_req <= 1'b0;
      err        <= 1'b0;

      // A byte landing on the expiry cycle is taken as data, not as a stall.
      if (parsing && expired && !rx_valid) begin
        err       <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (rx_valid) begin
              if (rx_data == CMD_MATMUL && !core_busy) begin
                err_code     <= ERR_NONE;
                byte_cnt_reg <= '0;
                state_reg    <= ST_DIM;
              end else if (rx_data == CMD_STATUS) begin
                status_req <= 1'b1;
                err_code   <= ERR_NONE;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_OPCODE;
              end
            end
          end

          ST_DIM: begin
            if (rx_valid) begin
              case (byte_cnt_reg)
                3'd0:    rows_a[7:0]       <= rx_data;
                3'd1:    rows_a[DIM_W-1:8] <= rx_data[DIM_W-9:0];
                3'd2:    cols_a[7:0]       <= rx_data;
                3'd3:    cols_a[DIM_W-1:8] <= rx_data[DIM_W-9:0];
                3'd4:    cols_b[7:0]       <= rx_data;
                3'd5:    cols_b[DIM_W-1:8] <= rx_data[DIM_W-9:0];
                default: ;
              endcase
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
              if (byte_cnt_reg == 3'd5) begin
                state_reg <= ST_CHECK;
              end
            end
          end

          ST_CHECK: begin
            if (dims_bad) begin
              err       <= 1'b1;
              err_code  <= ERR_DIMS;
              state_reg <= ST_IDLE;
            end else begin
              sel_reg   <= 1'b0;
              index_reg <= '0;
              state_reg <= ST_ELEM_LO;
            end
          end

          ST_ELEM_LO: begin
            if (rx_valid) begin
              lo_reg    <= rx_data;
              state_reg <= ST_ELEM_HI;
            end
          end

          ST_ELEM_HI: begin
            if (rx_valid) begin
              wr_en   <= 1'b1;
              wr_sel  <= sel_reg;
              wr_addr <= index_reg;
              wr_data <= DATA_W'({rx_data, lo_reg});
              if (!sel_reg && last_a) begin
                sel_reg   <= 1'b1;
                index_reg <= '0;
                state_reg <= ST_ELEM_LO;
              end else if (sel_reg && last_b) begin
                state_reg <= ST_FIRE;
              end else begin
                index_reg <= index_reg + ADDR_W'(1);
                state_reg <= ST_ELEM_LO;
              end
            end
          end

          ST_FIRE: begin
            start     <= 1'b1;
            state_reg <= ST_IDLE;
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser: packets are built from matrices and the
// expected buffer writes come from that matrix model, compared against a write log.
module tb_uart_cmd_parser;

  localparam int TO = 60;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        core_busy;
  logic        wr_en;
  logic        wr_sel;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rows_a;
  logic [15:0] cols_a;
  logic [15:0] cols_b;
  logic        start;
  logic        status_req;
  logic        err;
  logic [1:0]  err_code;
  logic        parsing;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int status_cnt = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;
  logic [47:0] start_dims = '0;

  wr_t        wr_log[$];
  wr_t        exp_q[$];
  logic [7:0] pkt_q[$];

  uart_cmd_parser #(
    .DATA_W(16), .DIM_W(16), .ADDR_W(8), .MAX_ELEMS(256), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .core_busy(core_busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .rows_a(rows_a), .cols_a(cols_a), .cols_b(cols_b),
    .start(start), .status_req(status_req), .err(err), .err_code(err_code),
    .parsing(parsing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_log.push_back(wr_t'{wr_sel, wr_addr, wr_data});
      last_wr_cyc <= cyc;
    end
    if (start) begin
      start_cnt  <= start_cnt + 1;
      start_cyc  <= cyc;
      start_dims <= {rows_a, cols_a, cols_b};
    end
    if (err)        err_cnt    <= err_cnt + 1;
    if (status_req) status_cnt <= status_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Packet = opcode, three LE dims, then A and B row-major as LE 16-bit words.
  task automatic build_packet(input int r, input int c, input int cb,
                              input bit with_elems, input bit seq);
    int v;
    int cnt;
    int n;
    pkt_q.delete();
    exp_q.delete();
    cnt = 1;
    pkt_q.push_back(8'h01);
    pkt_q.push_back(r[7:0]);  pkt_q.push_back(r[15:8]);
    pkt_q.push_back(c[7:0]);  pkt_q.push_back(c[15:8]);
    pkt_q.push_back(cb[7:0]); pkt_q.push_back(cb[15:8]);
    if (with_elems) begin
      for (int m = 0; m < 2; m++) begin
        n = (m == 0) ? r * c : c * cb;
        for (int i = 0; i < n; i++) begin
          v = seq ? cnt : int'($urandom_range(0, 65535));
          cnt++;
          pkt_q.push_back(v[7:0]);
          pkt_q.push_back(v[15:8]);
          exp_q.push_back(wr_t'{m[0], i[7:0], v[15:0]});
        end
      end
    end
  endtask

  // The host must leave one idle cycle after the last dim byte.
  task automatic send_packet(input int max_gap, input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (i == 7) idle(1);
      if (i > first && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(pkt_q[i]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; core_busy = 1'b0;
    idle(3);
    total++;
    if ({wr_en, wr_sel, wr_addr, wr_data, rows_a, cols_a, cols_b, start, status_req,
         err, err_code, parsing} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got wr_en=%b start=%b err=%b code=%0d parsing=%b want all 0",
               wr_en, start, err, err_code, parsing);
    end
    rst_n = 1'b1;
    idle(2);
    $display("reset released");
  endtask

  task automatic test_matmul;
    int base, s0, e0;
    build_packet(2, 2, 2, 1'b1, 1'b1);
    base = wr_log.size(); s0 = start_cnt; e0 = err_cnt;
    send_packet(0, 0, pkt_q.size());
    idle(3);
    total++;
    if (wr_log.size() - base !== exp_q.size()) begin
      bad++;
      $display("FAIL matmul_wr_count got %0d want %0d", wr_log.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
      total++;
      if (wr_log[base + i] !== exp_q[i]) begin
        bad++;
        $display("FAIL matmul_wr[%0d] got %h want %h", i, wr_log[base + i], exp_q[i]);
      end
    end
    total++;
    if (start_cnt - s0 !== 1) begin
      bad++; $display("FAIL matmul_start_count got %0d want 1", start_cnt - s0);
    end
    total++;
    if (start_cyc !== last_wr_cyc + 1) begin
      bad++; $display("FAIL matmul_start_timing got cyc %0d want %0d", start_cyc, last_wr_cyc + 1);
    end
    total++;
    if (start_dims !== {16'd2, 16'd2, 16'd2}) begin
      bad++; $display("FAIL matmul_dims got %h want 000200020002", start_dims);
    end
    total++;
    if (err_cnt !== e0) begin
      bad++; $display("FAIL matmul_err got %0d errs want 0", err_cnt - e0);
    end
    $display("matmul 2x2x2 packet: %0d writes", wr_log.size() - base);
  endtask

  task automatic test_status_opcode;
    int base;
    base = wr_log.size();
    send_byte(8'h03);
    total++;
    if (status_req !== 1'b1) begin
      bad++; $display("FAIL status_pulse got %b want 1", status_req);
    end
    idle(1);
    total++;
    if (status_req !== 1'b0) begin
      bad++; $display("FAIL status_width got %b want 0", status_req);
    end
    send_byte(8'h7F);
    total++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      bad++; $display("FAIL opcode_err got err=%b code=%0d want 1/1", err, err_code);
    end
    idle(1);
    total++;
    if (err !== 1'b0 || err_code !== 2'd1 || parsing !== 1'b0) begin
      bad++; $display("FAIL opcode_hold got err=%b code=%0d parsing=%b want 0/1/0", err, err_code, parsing);
    end
    send_byte(8'h03);
    total++;
    if (err_code !== 2'd0) begin
      bad++; $display("FAIL status_clears_code got %0d want 0", err_code);
    end
    total++;
    if (wr_log.size() !== base) begin
      bad++; $display("FAIL status_no_writes got %0d want 0", wr_log.size() - base);
    end
    $display("status/bad opcode bytes done");
  endtask

  task automatic test_busy;
    int base, s0;
    core_busy = 1'b1;
    send_byte(8'h01);
    total++;
    if (err !== 1'b1 || err_code !== 2'd1 || parsing !== 1'b0) begin
      bad++; $display("FAIL busy_reject got err=%b code=%0d parsing=%b want 1/1/0", err, err_code, parsing);
    end
    core_busy = 1'b0;
    idle(1);
    build_packet(1, 1, 1, 1'b1, 1'b0);
    base = wr_log.size(); s0 = start_cnt;
    send_byte(8'h01);
    total++;
    if (parsing !== 1'b1 || err_code !== 2'd0) begin
      bad++; $display("FAIL busy_retry got parsing=%b code=%0d want 1/0", parsing, err_code);
    end
    send_packet(0, 1, pkt_q.size());
    idle(3);
    total++;
    if (wr_log.size() - base !== 2 || start_cnt - s0 !== 1) begin
      bad++; $display("FAIL busy_retry_packet got wr=%0d start=%0d want 2/1", wr_log.size() - base, start_cnt - s0);
    end
    for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
      total++;
      if (wr_log[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL busy_wr[%0d] got %h want %h", i, wr_log[base + i], exp_q[i]);
      end
    end
    $display("busy reject then retry done");
  endtask

  task automatic test_dim_limits;
    int base, s0;
    int dl [4][3];
    bit ok [4];
    dl[0] = '{0, 2, 2};   ok[0] = 1'b0;
    dl[1] = '{17, 16, 1}; ok[1] = 1'b0;
    dl[2] = '{1, 256, 1}; ok[2] = 1'b1;
    dl[3] = '{1, 257, 1}; ok[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      build_packet(dl[k][0], dl[k][1], dl[k][2], ok[k], 1'b0);
      base = wr_log.size(); s0 = start_cnt;
      send_packet(0, 0, 7);
      total++;
      if (err !== 1'b0) begin
        bad++; $display("FAIL dims%0d_check_cycle got err=%b want 0", k, err);
      end
      if (!ok[k]) begin
        idle(1);
        total++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
          bad++; $display("FAIL dims%0d_err got err=%b code=%0d want 1/2", k, err, err_code);
        end
      end else begin
        send_packet(0, 7, pkt_q.size());
      end
      idle(3);
      total++;
      if (wr_log.size() - base !== exp_q.size() || start_cnt - s0 !== int'(ok[k])) begin
        bad++; $display("FAIL dims%0d_result got wr=%0d start=%0d want %0d/%0d",
                        k, wr_log.size() - base, start_cnt - s0, exp_q.size(), ok[k]);
      end
      for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
        total++;
        if (wr_log[base + i] !== exp_q[i]) begin
          bad++; $display("FAIL dims%0d_wr[%0d] got %h want %h", k, i, wr_log[base + i], exp_q[i]);
        end
      end
      $display("dims %0dx%0dx%0d accepted=%0d", dl[k][0], dl[k][1], dl[k][2], ok[k]);
    end
  endtask

  task automatic test_timeout;
    int base, s0, k;
    build_packet(2, 2, 2, 1'b1, 1'b0);
    base = wr_log.size(); s0 = start_cnt;
    send_packet(0, 0, 10);
    k = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      idle(1);
      if (err === 1'b1) begin
        k = i;
        break;
      end
    end
    total++;
    if (k !== TO) begin
      bad++; $display("FAIL timeout_latency got %0d cycles (0 = never) want %0d", k, TO);
    end
    total++;
    if (err_code !== 2'd3 || parsing !== 1'b0) begin
      bad++; $display("FAIL timeout_state got code=%0d parsing=%b want 3/0", err_code, parsing);
    end
    idle(2);
    total++;
    if (wr_log.size() - base !== 1 || start_cnt !== s0) begin
      bad++; $display("FAIL timeout_writes got wr=%0d start=%0d want 1/0", wr_log.size() - base, start_cnt - s0);
    end else begin
      total++;
      if (wr_log[base] !== exp_q[0]) begin
        bad++; $display("FAIL timeout_partial_wr got %h want %h", wr_log[base], exp_q[0]);
      end
    end
    $display("timeout after stall: %0d cycles", k);
  endtask

  task automatic test_timeout_race;
    int base, s0, e0;
    build_packet(2, 2, 2, 1'b1, 1'b0);
    base = wr_log.size(); s0 = start_cnt; e0 = err_cnt;
    send_packet(0, 0, 10);
    idle(TO - 1);
    send_packet(0, 10, pkt_q.size());
    idle(3);
    total++;
    if (err_cnt !== e0 || start_cnt - s0 !== 1 || wr_log.size() - base !== exp_q.size()) begin
      bad++; $display("FAIL timeout_race got err=%0d start=%0d wr=%0d want 0/1/%0d",
                      err_cnt - e0, start_cnt - s0, wr_log.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
      total++;
      if (wr_log[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL race_wr[%0d] got %h want %h", i, wr_log[base + i], exp_q[i]);
      end
    end
    $display("byte on expiry cycle accepted");
  endtask

  task automatic test_reset_mid;
    int base, s0;
    build_packet(2, 2, 2, 1'b1, 1'b0);
    s0 = start_cnt;
    send_packet(0, 0, 18);
    rst_n = 1'b0;
    #1;
    total++;
    if ({wr_en, wr_sel, wr_addr, wr_data, rows_a, cols_a, cols_b, start, status_req,
         err, err_code, parsing} !== '0) begin
      bad++;
      $display("FAIL reset_mid got wr_sel=%b addr=%0d rows_a=%0d parsing=%b want all 0",
               wr_sel, wr_addr, rows_a, parsing);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    total++;
    if (start_cnt !== s0) begin
      bad++; $display("FAIL reset_mid_start got %0d want 0", start_cnt - s0);
    end
    build_packet(1, 2, 1, 1'b1, 1'b0);
    base = wr_log.size(); s0 = start_cnt;
    send_packet(1, 0, pkt_q.size());
    idle(3);
    total++;
    if (wr_log.size() - base !== exp_q.size() || start_cnt - s0 !== 1) begin
      bad++; $display("FAIL reset_fresh got wr=%0d start=%0d want %0d/1", wr_log.size() - base, start_cnt - s0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
      total++;
      if (wr_log[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL reset_fresh_wr[%0d] got %h want %h", i, wr_log[base + i], exp_q[i]);
      end
    end
    $display("reset mid-B then fresh packet done");
  endtask

  task automatic test_random;
    int r, c, cb, mode, base, s0, e0;
    bit ok;
    for (int p = 0; p < 12; p++) begin
      mode = $urandom_range(0, 3);
      if (mode <= 1) begin
        r = $urandom_range(1, 6); c = $urandom_range(1, 6); cb = $urandom_range(1, 6);
      end else if (mode == 2) begin
        r = $urandom_range(0, 20); c = $urandom_range(0, 20); cb = $urandom_range(0, 20);
      end else begin
        r = $urandom_range(257, 65535); c = $urandom_range(1, 4); cb = $urandom_range(1, 4);
      end
      ok = (r != 0) && (c != 0) && (cb != 0) && (r * c <= 256) && (c * cb <= 256);
      build_packet(r, c, cb, ok, 1'b0);
      base = wr_log.size(); s0 = start_cnt; e0 = err_cnt;
      send_packet(2, 0, pkt_q.size());
      idle(3);
      total++;
      if (wr_log.size() - base !== exp_q.size() || start_cnt - s0 !== int'(ok) ||
          err_cnt - e0 !== int'(!ok)) begin
        bad++; $display("FAIL rand%0d_result got wr=%0d start=%0d err=%0d want %0d/%0d/%0d",
                        p, wr_log.size() - base, start_cnt - s0, err_cnt - e0, exp_q.size(), ok, !ok);
      end
      total++;
      if (err_code !== (ok ? 2'd0 : 2'd2)) begin
        bad++; $display("FAIL rand%0d_code got %0d want %0d", p, err_code, ok ? 0 : 2);
      end
      if (ok) begin
        total++;
        if (start_dims !== {r[15:0], c[15:0], cb[15:0]}) begin
          bad++; $display("FAIL rand%0d_dims got %h want %h", p, start_dims, {r[15:0], c[15:0], cb[15:0]});
        end
      end
      for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++) begin
        total++;
        if (wr_log[base + i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_wr[%0d] got %h want %h", p, i, wr_log[base + i], exp_q[i]);
        end
      end
      $display("random packet %0d dims %0dx%0dx%0d accepted=%0d", p, r, c, cb, ok);
    end
  endtask

  initial begin
    test_reset;
    test_matmul;
    test_status_opcode;
    test_busy;
    test_dim_limits;
    test_timeout;
    test_timeout_race;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser between the UART receiver and the matrix-multiply core on the DE10-Lite design. Consumes one received byte per strobe, decodes the host protocol (CMD_MATMUL 0x01, CMD_STATUS 0x03), and latches little-endian 16-bit dimensions. Streams 16-bit little-endian elements of A, then B, into the operand buffers, then pulses `start` to the core. Malformed or stalled packets are rejected with an error code so the host can retry.

## Interface
- `DATA_W`, 16: element width.
- `DIM_W`, 16: dimension field width.
- `ADDR_W`, 8: operand buffer address width.
- `MAX_ELEMS`, 256: maximum elements per matrix; must be ≤ 2^ADDR_W.
- `TIMEOUT_CYC`, 43400: idle cycles between bytes (10 byte times at 115200 baud, 50 MHz clock) before a packet is aborted.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in 8: received byte.
- `core_busy` in 1: matmul core computing or transmitting.
- `wr_en` out 1: operand buffer write strobe.
- `wr_sel` out 1: 0 = matrix A, 1 = matrix B.
- `wr_addr` out ADDR_W: row-major element index.
- `wr_data` out DATA_W: element value.
- `rows_a`, `cols_a`, `cols_b` out DIM_W each: latched dimensions, stable from `start` until next accepted CMD_MATMUL.
- `start` out 1: one-cycle pulse, operands complete.
- `status_req` out 1: one-cycle pulse, host requested status.
- `err` out 1: one-cycle pulse on packet rejection.
- `err_code` out 2: last error; 0 none, 1 bad opcode / busy, 2 bad dims, 3 timeout. Held until next accepted command.
- `parsing` out 1: high in every state except IDLE.

## Operation
- All outputs reset to 0; dims reset to 0; state IDLE.
- States: IDLE, DIM, CHECK, ELEM_LO, ELEM_HI, FIRE.
- IDLE, byte 0x01, `core_busy`=0: clear `err_code`, clear byte counter, go to DIM.
- IDLE, byte 0x01, `core_busy`=1: `err` pulse, code 1, stay IDLE.
- IDLE, byte 0x03: `status_req` pulse, clear `err_code`, stay IDLE. Accepted regardless of `core_busy`.
- IDLE, any other byte: `err` pulse, code 1.
- DIM: 6 bytes in order rows_a LSB/MSB, cols_a LSB/MSB, cols_b LSB/MSB, then CHECK.
- CHECK (1 cycle, ignores `rx_valid`; the host cannot send faster): compute `n_a` = rows_a·cols_a and `n_b` = cols_a·cols_b, full 2·DIM_W-bit products.
  - Any dim = 0 or either product > MAX_ELEMS: `err` pulse, code 2, go to IDLE.
  - Otherwise go to ELEM_LO with `wr_sel`=0 and element index 0.
- ELEM_LO: latch low byte, go to ELEM_HI.
- ELEM_HI: register the write on the next edge: `wr_en`=1, `wr_data` = {hi, lo}, `wr_addr` = index.
  - Index increments after each write.
  - When index reaches `n_a` - 1 with `wr_sel`=0: set `wr_sel`=1, index 0.
  - When index reaches `n_b` - 1 with `wr_sel`=1: go to FIRE.
  - Otherwise return to ELEM_LO.
- FIRE: pulse `start`, go to IDLE.
- Bytes inside a packet are payload and are never decoded as opcodes, including 0x01 and 0x03.
- Timeout: a counter runs in every non-IDLE state and clears on each `rx_valid`. When it reaches TIMEOUT_CYC: `err` pulse, code 3, go to IDLE. Buffer contents written so far are left as is.
- Reset mid-packet: immediate return to IDLE, all outputs 0, no `start`.

## Timing
- `status_req` / `err` (opcode): asserted the cycle after the `rx_valid` edge.
- `err` for bad dims: 2 cycles after the 6th dim byte (CHECK, then pulse).
- `wr_en`: 1 cycle after the MSB byte strobe, high exactly 1 cycle.
- `start`: the cycle after the final `wr_en`; dims stable in that cycle.
- Timeout `err`: TIMEOUT_CYC cycles after the last accepted byte strobe.
- `rx_valid` arriving in the same cycle as timeout expiry: the byte wins and the counter clears.
- Throughput: one byte per cycle supported, except the single cycle in CHECK.

## Structure
- Package `uart_cmd_pkg`:
  - opcode constants CMD_MATMUL = 8'h01, CMD_STATUS = 8'h03;
  - state enum `parse_state_t`;
  - error enum `parse_err_t`.
- Sub-module `byte_timeout`: counter with `clear`, `enable`, `expired` and parameter TIMEOUT_CYC. Reused by the TX side.
- The matmul core and operand buffers are outside this block.

## Test plan
- 2×2×2 packet: bytes 01 02 00 02 00 02 00 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08 00 → A writes addr 0–3 data 1, 2, 3, 4; B writes addr 0–3 data 5, 6, 7, 8; dims 2/2/2; one `start` the cycle after the last write.
- Byte 03 while idle → `status_req` pulse 1 cycle later, no writes. Byte 7F → `err`, code 1.
- 0x01 with `core_busy`=1 → `err` code 1, no state change. Repeated after `core_busy` falls → accepted.
- Dims 00 00 02 00 02 00 → `err` code 2, no `wr_en`. Dims 17×16 (272 > 256) → `err` code 2.
- Stall after the 3rd A byte for TIMEOUT_CYC → `err` code 3, `parsing`=0, no `start`. A following valid packet completes normally.
- `rst_n` low in the middle of matrix B → all outputs 0 immediately. After release, byte 0x01 starts a fresh packet.
